// File: rtl/charattr_row_buffer_pkg.sv
// Shared sizing constants and clear-FSM state type for the character-attribute row buffer.
package charattr_row_buffer_pkg;

  localparam int CHARATTR_WIDTH    = 32;
  localparam int TEXT_COLUMNS      = 80;
  localparam int COLUMN_ADDR_WIDTH = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/charattr_row_buffer_ram.sv
// Simple dual-port block RAM holding both row banks, addressed as {bank, column}.
module charattr_row_ram #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH:0]   waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH:0]   raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**(ADDR_WIDTH+1)];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/charattr_row_buffer.sv
// Double-buffered character-attribute row store with full/release bank handshake
// and a self-timed clear of the write bank.
module charattr_row_buffer
  import charattr_row_buffer_pkg::*;
#(
  parameter int               WIDTH       = CHARATTR_WIDTH,
  parameter int               COLUMNS     = TEXT_COLUMNS,
  parameter int               ADDR_WIDTH  = COLUMN_ADDR_WIDTH,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  clr_start,
  output logic                  clr_busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  rd_release
);

  localparam logic [ADDR_WIDTH:0]   COLS     = COLUMNS[ADDR_WIDTH:0];
  localparam int                    LAST_INT = COLUMNS - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = LAST_INT[ADDR_WIDTH-1:0];

  clr_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  wbank_reg, rbank_reg;
  logic [1:0]            full_reg, full_next;
  logic                  clr_busy_reg;
  logic                  rd_zero_reg;

  logic                  commit, do_release;
  logic                  wr_in_range, rd_in_range;
  logic                  ram_we;
  logic [ADDR_WIDTH:0]   ram_waddr;
  logic [WIDTH-1:0]      ram_wdata;
  logic [WIDTH-1:0]      ram_rdata;

  assign wr_ready    = !full_reg[wbank_reg] && (state_reg == IDLE);
  assign rd_valid    = full_reg[rbank_reg];
  assign commit      = wr_done && wr_ready;
  assign do_release  = rd_release && rd_valid;
  assign wr_in_range = ({1'b0, wr_addr} < COLS);
  assign rd_in_range = ({1'b0, rd_addr} < COLS);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_start && wr_ready && !wr_done) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + ADDR_WIDTH'(1);
        if (cnt_reg == LAST_COL) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Commit and release never hit the same flag: a shared bank is either full or empty.
  always_comb begin
    full_next = full_reg;
    if (commit) begin
      full_next[wbank_reg] = 1'b1;
    end
    if (do_release) begin
      full_next[rbank_reg] = 1'b0;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {wbank_reg, wr_addr};
    ram_wdata = wr_data;
    if (state_reg == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = {wbank_reg, cnt_reg};
      ram_wdata = CLEAR_VALUE;
    end else if (wr_en && wr_ready && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wbank_reg    <= 1'b0;
      rbank_reg    <= 1'b0;
      full_reg     <= 2'b00;
      clr_busy_reg <= 1'b0;
      rd_zero_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wbank_reg    <= wbank_reg ^ commit;
      rbank_reg    <= rbank_reg ^ do_release;
      full_reg     <= full_next;
      clr_busy_reg <= (state_next == CLEAR);
      rd_zero_reg  <= !rd_in_range;
    end
  end

  charattr_row_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr ({rbank_reg, rd_addr}),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset, so reset and out-of-range reads are masked here.
  assign rd_data  = rd_zero_reg ? '0 : ram_rdata;
  assign clr_busy = clr_busy_reg;

endmodule

// File: doc/charattr_row_buffer.md
# charattr_row_buffer

Parametrised, double-buffered character-attribute row store. The row builder fills one bank while the video generator reads the other, and the two banks swap under a full/release handshake. The block also has a self-timed clear that writes a blank attribute word into every column of the write bank. It replaces the single-bank 80×32 row RAM between the text-memory fetcher and the pixel pipeline.

## Interface
- `WIDTH`, 32: attribute word width in bits.
- `COLUMNS`, 80: valid columns per row; must satisfy `COLUMNS <= 2**ADDR_WIDTH`.
- `ADDR_WIDTH`, 7: column address width.
- `CLEAR_VALUE`, `{WIDTH{1'b0}}`: word written by the clear operation.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `wr_en`, in, 1: write `wr_data` to column `wr_addr` of the write bank.
- `wr_addr`, in, `ADDR_WIDTH`: write column.
- `wr_data`, in, `WIDTH`: write word.
- `wr_done`, in, 1: pulse; the current write bank is complete.
- `wr_ready`, out, 1: the write bank is free and no clear is running.
- `clr_start`, in, 1: pulse; start clearing the write bank.
- `clr_busy`, out, 1: a clear is in progress.
- `rd_addr`, in, `ADDR_WIDTH`: read column.
- `rd_data`, out, `WIDTH`: registered read word.
- `rd_valid`, out, 1: the read bank holds a complete row.
- `rd_release`, in, 1: pulse; the reader has finished with the read bank.

## Operation
- Storage is 2×`2**ADDR_WIDTH` words, addressed as `{bank, column}`.
- State registers:
  - `wbank` and `rbank` are 1-bit bank pointers.
  - `full[1:0]` holds one flag per bank.
  - The clear FSM is {IDLE, CLEAR} with an `ADDR_WIDTH`-bit counter.
- Combinational outputs: `wr_ready = !full[wbank] && state==IDLE`; `rd_valid = full[rbank]`.
- Write:
  - When `wr_en && wr_ready && wr_addr < COLUMNS`, the word is stored at `{wbank, wr_addr}`.
  - Otherwise the write is dropped silently.
- Commit: `wr_done && wr_ready` sets `full[wbank]` and toggles `wbank`. `wr_done` without `wr_ready` is ignored.
- Release: `rd_release && rd_valid` clears `full[rbank]` and toggles `rbank`. `rd_release` without `rd_valid` is ignored.
- Commit and release in the same cycle are both applied. They always target different flags, except when `wbank==rbank`; in that case the bank is either full (commit is blocked) or empty (release is blocked), so there is no conflict.
- Clear:
  - In IDLE, `clr_start && wr_ready && !wr_done` enters CLEAR with counter 0.
  - Each CLEAR cycle writes `CLEAR_VALUE` to `{wbank, counter}` and increments the counter.
  - After writing column `COLUMNS-1`, the FSM returns to IDLE.
  - During CLEAR, `wr_en`, `wr_done` and `clr_start` are ignored.
  - Clear does not set `full`; the writer must still issue `wr_done`.
- Read: `rd_data` is loaded from `{rbank, rd_addr}` every cycle. If `rd_addr >= COLUMNS`, `rd_data` loads 0.
- Write-then-read of the same word in the same cycle cannot happen, because the read bank is never the write bank while it is full.

## Timing
- Reset (`reset==0` at an edge) sets:
  - `wbank=rbank=0`, `full=2'b00`, state IDLE, counter 0.
  - `rd_data=0`, `clr_busy=0`.
  - Resulting outputs: `wr_ready=1`, `rd_valid=0`.
- Memory contents are not reset.
- Reset during CLEAR aborts the clear. Columns already written keep `CLEAR_VALUE`.
- Read latency is 1 cycle: `rd_addr` sampled at edge N appears on `rd_data` after edge N.
- Bank selection for a read uses `rbank` at edge N. The read issued in the same cycle as `rd_release` still returns the old bank.
- `wr_done` at edge N: `wr_ready` and `rd_valid` reflect the new flags after edge N.
- Clear takes exactly `COLUMNS` cycles. `clr_busy` is registered: high from the edge after `clr_start` until the edge that writes the last column. `wr_ready` returns to 1 on the following cycle.
- Throughput: one write and one read per cycle, sustained.

## Structure
- The shared package holds `CHARATTR_WIDTH` (32), `TEXT_COLUMNS` (80) and `COLUMN_ADDR_WIDTH` (7). Top-level parameter defaults come from these.
- One sub-module, `charattr_row_ram`:
  - single-clock simple dual-port RAM, depth `2**(ADDR_WIDTH+1)`, width `WIDTH`;
  - one write port and one registered read port, with no reset on the array.
- The FSM, flags, pointers, address-range checks and the zeroing of out-of-range reads stay in `charattr_row_buffer`.

## Test plan
- Reset, then write columns 0..79 with `data = 0xA5000000 | col`, then pulse `wr_done` → `rd_valid=1` and `wr_ready=1` (bank 1 free). Reading column 5 gives `0xA5000005` one cycle later.
- Fill and commit both banks without release → `wr_ready=0`. A `wr_en` at column 3 with `0xFFFFFFFF` is dropped. A later `rd_release` → `wr_ready=1` and `rd_valid=1` (second bank).
- `clr_start` in IDLE → `clr_busy` high for exactly 80 cycles. After `wr_done` and release of the previous bank, all 80 columns read 0 (`CLEAR_VALUE`). Column 80 and column 127 read 0.
- `wr_done` and `rd_release` in the same cycle with one bank full → the flags swap correctly, `rd_valid` stays 1, and `rd_data` for the next read comes from the newly committed bank.
- Assert `reset=0` 20 cycles into a clear → `clr_busy=0`, `wr_ready=1`, `rd_valid=0`. The next `clr_start` restarts from column 0 and takes a full 80 cycles.
- Reads at `rd_addr >= 80`, and `wr_en` at `wr_addr=100` → `rd_data=0`, and no valid column of either bank changes.
